// File: rtl/cpu_bus_seq_pkg.sv
// Shared definitions for the 65c816 byte-bus access sequencer.
// Address/data widths, wrap-mode encodings and sequencer states.
package cpu_bus_seq_pkg;

    localparam int CPU_ADDR_W = 24;
    localparam int CPU_DATA_W = 8;

    typedef enum logic [1:0] {
        WRAP_LIN  = 2'b00,
        WRAP_BANK = 2'b01,
        WRAP_PAGE = 2'b10,
        WRAP_RSVD = 2'b11
    } wrap_t;

    // Response cycle after accept: read L*(W+2)+1, write L*(W+1)+1, error 1
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/cpu_bus_seq_addr_wrap.sv
// Byte address generator honouring 65c816 linear, bank and page wrap.
// Purely combinational; reserved mode behaves as linear.
module cpu_addr_wrap
    import cpu_bus_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = CPU_ADDR_W,
    parameter int OFF_WIDTH  = 2
) (
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [OFF_WIDTH-1:0]  offset,
    input  logic [1:0]            mode,
    output logic [ADDR_WIDTH-1:0] addr
);

    localparam logic [ADDR_WIDTH-1:0] BANK_M = ADDR_WIDTH'(32'h0000_FFFF);
    localparam logic [ADDR_WIDTH-1:0] PAGE_M = ADDR_WIDTH'(32'h0000_00FF);

    logic [ADDR_WIDTH-1:0] sum;

    always_comb begin
        sum = base + ADDR_WIDTH'(offset);
        unique case (wrap_t'(mode))
            WRAP_BANK: addr = (base & ~BANK_M) | (sum & BANK_M);
            WRAP_PAGE: addr = (base & ~PAGE_M) | (sum & PAGE_M);
            default:   addr = sum;
        endcase
    end

endmodule

// File: rtl/cpu_bus_seq.sv
// Multi-byte request sequencer onto the byte-wide external bus.
// One bus cycle per byte, little-endian read assembly, single response pulse.
module cpu_bus_seq
    import cpu_bus_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = CPU_DATA_W,
    parameter int ADDR_WIDTH  = CPU_ADDR_W,
    parameter int MAX_BYTES   = 3,
    parameter int WAIT_STATES = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [$clog2(MAX_BYTES+1)-1:0]  req_len,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic [1:0]                      req_wrap,
    input  logic [MAX_BYTES*DATA_WIDTH-1:0] req_wdata,
    output logic                            rsp_valid,
    output logic                            rsp_err,
    output logic [MAX_BYTES*DATA_WIDTH-1:0] rsp_rdata,
    input  logic [DATA_WIDTH-1:0]           data_in,
    output logic                            re,
    output logic                            we,
    output logic [ADDR_WIDTH-1:0]           addr,
    output logic [DATA_WIDTH-1:0]           data_out
);

    localparam int LW = $clog2(MAX_BYTES+1);
    localparam int BW = MAX_BYTES*DATA_WIDTH;

    state_t                state;
    logic                  wr_q;
    logic [LW-1:0]         len_q;
    logic [LW-1:0]         idx;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [1:0]            wrap_q;
    logic [BW-1:0]         wdata_q;
    logic [3:0]            ws;

    logic [LW-1:0]         nxt_idx;
    logic [ADDR_WIDTH-1:0] wrap_base;
    logic [ADDR_WIDTH-1:0] wrap_addr;
    logic [1:0]            wrap_mode;
    logic [BW-1:0]         wsrc;
    logic [DATA_WIDTH-1:0] byte_sel;
    logic                  last;
    logic                  strobe_end;
    logic                  len_ok;

    assign req_ready = (state == ST_IDLE);

    // In IDLE the generator looks at the incoming request so byte 0 is ready at accept
    always_comb begin
        len_ok     = (req_len != '0) && (32'(req_len) <= 32'(MAX_BYTES));
        last       = (idx == len_q - LW'(1));
        strobe_end = (ws == 4'(WAIT_STATES));
        nxt_idx    = idx + LW'(1);
        wrap_base  = base_q;
        wrap_mode  = wrap_q;
        wsrc       = wdata_q;
        if (state == ST_IDLE) begin
            nxt_idx   = '0;
            wrap_base = req_addr;
            wrap_mode = req_wrap;
            wsrc      = req_wdata;
        end
        byte_sel = DATA_WIDTH'(wsrc >> (nxt_idx * DATA_WIDTH));
    end

    cpu_addr_wrap #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .OFF_WIDTH  (LW)
    ) u_wrap (
        .base   (wrap_base),
        .offset (nxt_idx),
        .mode   (wrap_mode),
        .addr   (wrap_addr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            wr_q      <= 1'b0;
            len_q     <= '0;
            idx       <= '0;
            base_q    <= '0;
            wrap_q    <= '0;
            wdata_q   <= '0;
            ws        <= '0;
            re        <= 1'b0;
            we        <= 1'b0;
            addr      <= '0;
            data_out  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wr_q      <= req_write;
                        len_q     <= req_len;
                        base_q    <= req_addr;
                        wrap_q    <= req_wrap;
                        wdata_q   <= req_wdata;
                        idx       <= '0;
                        ws        <= '0;
                        rsp_rdata <= '0;
                        if (len_ok) begin
                            state    <= ST_ACCESS;
                            rsp_err  <= 1'b0;
                            re       <= !req_write;
                            we       <= req_write;
                            addr     <= wrap_addr;
                            data_out <= req_write ? byte_sel : '0;
                        end else begin
                            state     <= ST_DONE;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!strobe_end) begin
                        ws <= ws + 4'd1;
                    end else begin
                        ws <= '0;
                        if (!wr_q) begin
                            re    <= 1'b0;
                            state <= ST_CAPTURE;
                        end else if (last) begin
                            we        <= 1'b0;
                            state     <= ST_DONE;
                            rsp_valid <= 1'b1;
                        end else begin
                            idx      <= nxt_idx;
                            addr     <= wrap_addr;
                            data_out <= byte_sel;
                        end
                    end
                end
                ST_CAPTURE: begin
                    rsp_rdata <= rsp_rdata | (BW'(data_in) << (idx * DATA_WIDTH));
                    if (last) begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                    end else begin
                        idx   <= nxt_idx;
                        re    <= 1'b1;
                        addr  <= wrap_addr;
                        state <= ST_ACCESS;
                    end
                end
                ST_DONE: begin
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_seq.sv
// Directed bench for cpu_bus_seq: two instances, zero and two wait states.
// Byte memory answers for the address held on the bus.
module tb_cpu_bus_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rv0 = 1'b0;
    logic        rv1 = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_len = '0;
    logic [23:0] req_addr = '0;
    logic [1:0]  req_wrap = '0;
    logic [23:0] req_wdata = '0;
    logic [7:0]  d0 = '0;
    logic [7:0]  d1 = '0;

    logic        rdy0, rdy1, rv_o0, rv_o1, err0, err1;
    logic [23:0] rd0, rd1, a0, a1;
    logic        re0, re1, we0, we1;
    logic [7:0]  do0, do1;

    logic        sel = 1'b0;
    logic        m_ready, m_rv, m_err, m_re, m_we;
    logic [23:0] m_rdata, m_addr;
    logic [7:0]  m_dout;

    logic [7:0]  mem [int];
    logic [23:0] la [$];
    logic [7:0]  ld [$];
    logic        lw [$];
    int          both_hi = 0;
    int          vecs = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    cpu_bus_seq #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rdy0),
        .req_write(req_write), .req_len(req_len), .req_addr(req_addr),
        .req_wrap(req_wrap), .req_wdata(req_wdata), .rsp_valid(rv_o0),
        .rsp_err(err0), .rsp_rdata(rd0), .data_in(d0), .re(re0),
        .we(we0), .addr(a0), .data_out(do0)
    );

    cpu_bus_seq #(.WAIT_STATES(2)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1),
        .req_write(req_write), .req_len(req_len), .req_addr(req_addr),
        .req_wrap(req_wrap), .req_wdata(req_wdata), .rsp_valid(rv_o1),
        .rsp_err(err1), .rsp_rdata(rd1), .data_in(d1), .re(re1),
        .we(we1), .addr(a1), .data_out(do1)
    );

    always_comb begin
        m_ready = sel ? rdy1 : rdy0;
        m_rv    = sel ? rv_o1 : rv_o0;
        m_err   = sel ? err1 : err0;
        m_rdata = sel ? rd1 : rd0;
        m_re    = sel ? re1 : re0;
        m_we    = sel ? we1 : we0;
        m_addr  = sel ? a1 : a0;
        m_dout  = sel ? do1 : do0;
    end

    always @(negedge clk) begin
        d0 = mem.exists(int'(a0)) ? mem[int'(a0)] : 8'h00;
        d1 = mem.exists(int'(a1)) ? mem[int'(a1)] : 8'h00;
        if (m_re || m_we) begin
            la.push_back(m_addr);
            ld.push_back(m_dout);
            lw.push_back(m_we);
        end
        if ((re0 && we0) || (re1 && we1)) both_hi++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (m_rv) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_req(input logic s, input logic wr, input logic [1:0] len,
                           input logic [23:0] a, input logic [1:0] wrap,
                           input logic [23:0] wd, output int lat);
        @(negedge clk);
        sel       = s;
        req_write = wr;
        req_len   = len;
        req_addr  = a;
        req_wrap  = wrap;
        req_wdata = wd;
        if (s) rv1 = 1'b1;
        else   rv0 = 1'b1;
        for (int n = 0; n < 50 && !m_ready; n++) @(negedge clk);
        la.delete();
        ld.delete();
        lw.delete();
        @(posedge clk);
        #1;
        rv0 = 1'b0;
        rv1 = 1'b0;
        wait_rsp(lat);
        @(negedge clk);
        check("rsp_pulse_width", 32'(m_rv), 0);
    endtask

    int lat;
    int seen;
    int acc;
    int nlow;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_re", 32'(re0), 0);
        check("rst_we", 32'(we0), 0);
        check("rst_addr", 32'(a0), 0);
        check("rst_dout", 32'(do0), 0);
        check("rst_rv", 32'(rv_o0), 0);
        check("rst_err", 32'(err0), 0);
        check("rst_rdata", 32'(rd0), 0);
        check("rst_ready", 32'(rdy0), 1);

        mem[32'h12FFFF] = 8'hAA;
        mem[32'h130000] = 8'hBB;
        mem[32'h130001] = 8'hCC;
        run_req(1'b0, 1'b0, 2'd3, 24'h12FFFF, 2'b00, 24'h0, lat);
        check("lin_lat", 32'(lat), 7);
        check("lin_rdata", 32'(m_rdata), 32'hCCBBAA);
        check("lin_err", 32'(m_err), 0);
        check("lin_nstrobe", 32'(la.size()), 3);
        if (la.size() == 3) begin
            check("lin_a0", 32'(la[0]), 32'h12FFFF);
            check("lin_a1", 32'(la[1]), 32'h130000);
            check("lin_a2", 32'(la[2]), 32'h130001);
            check("lin_rd_dout", 32'(ld[1]), 0);
        end

        run_req(1'b0, 1'b0, 2'd0, 24'h000040, 2'b00, 24'h0, lat);
        check("len0_lat", 32'(lat), 1);
        check("len0_err", 32'(m_err), 1);
        check("len0_rdata", 32'(m_rdata), 0);
        check("len0_nstrobe", 32'(la.size()), 0);

        run_req(1'b0, 1'b1, 2'd2, 24'h7EFFFF, 2'b01, 24'h001234, lat);
        check("bank_lat", 32'(lat), 3);
        check("bank_err", 32'(m_err), 0);
        check("bank_nstrobe", 32'(la.size()), 2);
        if (la.size() == 2) begin
            check("bank_a0", 32'(la[0]), 32'h7EFFFF);
            check("bank_d0", 32'(ld[0]), 32'h34);
            check("bank_a1", 32'(la[1]), 32'h7E0000);
            check("bank_d1", 32'(ld[1]), 32'h12);
            check("bank_we", 32'({lw[0], lw[1]}), 32'b11);
        end

        mem[32'h0001FF] = 8'h11;
        mem[32'h000100] = 8'h22;
        run_req(1'b1, 1'b0, 2'd2, 24'h0001FF, 2'b10, 24'h0, lat);
        check("page_lat", 32'(lat), 9);
        check("page_rdata", 32'(m_rdata), 32'h002211);
        check("page_nstrobe", 32'(la.size()), 6);
        if (la.size() == 6) begin
            check("page_a0", 32'(la[0]), 32'h0001FF);
            check("page_a2", 32'(la[2]), 32'h0001FF);
            check("page_a3", 32'(la[3]), 32'h000100);
            check("page_a5", 32'(la[5]), 32'h000100);
            check("page_we", 32'(lw[3]), 0);
        end

        run_req(1'b1, 1'b0, 2'd0, 24'h000100, 2'b00, 24'h0, lat);
        check("len0_w2_lat", 32'(lat), 1);
        check("len0_w2_err", 32'(m_err), 1);
        check("len0_w2_rdata", 32'(m_rdata), 0);

        mem[32'h000010] = 8'h5A;
        @(negedge clk);
        sel       = 1'b0;
        req_write = 1'b0;
        req_len   = 2'd3;
        req_addr  = 24'h000010;
        req_wrap  = 2'b00;
        rv0       = 1'b1;
        @(posedge clk);
        #1 rv0 = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_pre_re", 32'(re0), 1);
        check("mid_pre_addr", 32'(a0), 32'h11);
        check("mid_pre_rdata", 32'(rd0), 32'h5A);
        rst = 1'b0;
        #1;
        check("mid_re", 32'(re0), 0);
        check("mid_addr", 32'(a0), 0);
        check("mid_rdata", 32'(rd0), 0);
        check("mid_rv", 32'(rv_o0), 0);
        check("mid_ready", 32'(rdy0), 1);
        @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rv_o0) seen++;
        end
        check("mid_no_rsp", 32'(seen), 0);
        run_req(1'b0, 1'b0, 2'd1, 24'h000010, 2'b00, 24'h0, lat);
        check("post_lat", 32'(lat), 3);
        check("post_rdata", 32'(m_rdata), 32'h5A);
        check("post_err", 32'(m_err), 0);

        @(negedge clk);
        sel       = 1'b0;
        req_write = 1'b1;
        req_len   = 2'd1;
        req_addr  = 24'h000200;
        req_wrap  = 2'b00;
        req_wdata = 24'h000077;
        rv0       = 1'b1;
        check("b2b_ready0", 32'(rdy0), 1);
        la.delete();
        ld.delete();
        lw.delete();
        acc  = 0;
        nlow = 0;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_addr  = 24'h000201;
                req_wdata = 24'h000088;
            end
            if (rdy0) begin
                acc = k;
                break;
            end
            nlow++;
        end
        @(posedge clk);
        #1 rv0 = 1'b0;
        check("b2b_accept_cyc", 32'(acc), 3);
        check("b2b_ready_low", 32'(nlow), 2);
        wait_rsp(lat);
        check("b2b_lat", 32'(lat), 2);
        check("b2b_nstrobe", 32'(la.size()), 2);
        if (la.size() == 2) begin
            check("b2b_a0", 32'(la[0]), 32'h200);
            check("b2b_d0", 32'(ld[0]), 32'h77);
            check("b2b_a1", 32'(la[1]), 32'h201);
            check("b2b_d1", 32'(ld[1]), 32'h88);
        end

        check("re_we_overlap", 32'(both_hi), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/cpu_bus_seq.md
# cpu_bus_seq

Multi-byte memory access sequencer between the 65c816 core's execution logic and its byte-wide external bus. It accepts one request of 1..MAX_BYTES bytes, issues one bus cycle per byte with configurable wait states, and applies 65c816 address wrap rules (linear, bank, page). Read bytes are assembled little-endian; the result is returned as a single response pulse. The core uses it for operand fetch, 16/24-bit data, and pointer access.

## Interface
- DATA_WIDTH, 8: bus byte width.
- ADDR_WIDTH, 24: far address width; must be ≥16.
- MAX_BYTES, 3: maximum bytes per request.
- WAIT_STATES, 0: extra strobe cycles per byte, 0..15.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_len  in  $clog2(MAX_BYTES+1)  byte count.
- req_addr  in  ADDR_WIDTH  address of byte 0.
- req_wrap  in  2  00 linear, 01 bank wrap, 10 page wrap, 11 reserved (treated as linear).
- req_wdata  in  MAX_BYTES*DATA_WIDTH  byte i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  valid with rsp_valid; 1 = illegal length.
- rsp_rdata  out  MAX_BYTES*DATA_WIDTH  read bytes, same packing; unread bytes 0.
- data_in  in  DATA_WIDTH  bus read data.
- re, we  out  1  read and write strobes.
- addr  out  ADDR_WIDTH  bus address.
- data_out  out  DATA_WIDTH  bus write data.

## Operation
- States: IDLE, ACCESS, CAPTURE, DONE.
- IDLE: on req_valid, latch the whole request and set byte index i=0. len in 1..MAX_BYTES -> ACCESS. Otherwise -> DONE with err=1 and no bus activity.
- ACCESS: assert re (read) or we (write) for WAIT_STATES+1 cycles, using wait counter ws. addr = wrap(base,i). data_out = wdata byte i on writes and 0 on reads.
- End of ACCESS: a read goes to CAPTURE. A write increments i and goes to DONE when i==len-1, otherwise to ACCESS.
- CAPTURE (reads only): strobes low. Sample data_in into rdata byte i at the closing edge. If i==len-1 -> DONE, otherwise increment i and go to ACCESS.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata and rsp_err hold until the next accepted request.
- Wrap arithmetic, base B, offset i:
  - linear: (B+i) mod 2^ADDR_WIDTH.
  - bank: upper bits of B kept; B[15:0]+i mod 2^16.
  - page: upper bits of B kept; B[7:0]+i mod 2^8.
- rdata is cleared to 0 on request acceptance.
- req_valid outside IDLE is ignored. The requester holds the request until req_ready.
- Reset in any state: immediate abandon, no response, return to IDLE.

## Timing
- Reset values: re=0, we=0, addr=0, data_out=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, state IDLE (req_ready=1).
- The memory presents data for the previous cycle's addr. data_in is valid in CAPTURE.
- Accept edge = cycle 0.
- Read of L bytes: rsp_valid in cycle L*(WAIT_STATES+2)+1.
- Write of L bytes: rsp_valid in cycle L*(WAIT_STATES+1)+1.
- Error: rsp_valid in cycle 1.
- Minimum spacing between accepts is latency+1; there is one mandatory IDLE cycle after DONE.
- re and we are never high in the same cycle. Strobes are registered outputs.

## Structure
- Add to the shared cpu_defines include: far address width, data width, wrap-mode encodings, and state encodings.
- One combinational sub-module, cpu_addr_wrap: inputs base, offset, mode; output address. It is instantiated once, driven by i.
- Latency formulas live as comments next to the state constants for bench reuse.

## Test plan
- Linear read, len=3, addr=0x12FFFF, W=0: addr sequence 0x12FFFF, 0x130000, 0x130001. Memory bytes AA,BB,CC -> rsp_rdata=0xCCBBAA; rsp_valid in cycle 7.
- Bank-wrap write, len=2, addr=0x7EFFFF, wdata=0x1234: we at 0x7EFFFF (data 0x34), then 0x7E0000 (data 0x12); rsp_valid in cycle 3; re stays 0.
- Page-wrap read, len=2, addr=0x0001FF, W=2: addresses 0x0001FF, 0x000100. Each strobe lasts 3 cycles; rsp_valid in cycle 9; rsp_rdata[23:16]=0.
- Illegal lengths: len=0 and len=4 -> rsp_err=1 in cycle 1. No re or we at any point; rsp_rdata=0.
- Reset asserted during the second byte of a 3-byte read: re, addr, rsp_* drop to 0 immediately. No rsp_valid follows; the next request completes normally.
- Back-to-back: req_valid held high across two requests. The second is accepted only in the IDLE cycle after DONE. req_ready is 0 from acceptance through DONE.
